uram_port_master: RTL and testbench
===================================

URAM_PORT_MASTER -- requirements
Module: uram_port_master

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, giving cycles from MEM_EN read issue to valid MEM_DOUT; legal range 1..8.
REQ-002 SHALL have parameter RSP_DEPTH, default 8, giving the response FIFO entry count; power of two, 4..64.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port req_valid / req_ready, input / output, 1 bit each: request handshake.
REQ-006 SHALL have port req_wr, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have ports req_addr (input, 23 bits), req_bwe (input, 9 bits) and req_data (input, 72 bits).
REQ-008 SHALL have port rsp_valid / rsp_ready, output / input, 1 bit each: response handshake.
REQ-009 SHALL have port rsp_data, output, 72 bits, and port rsp_wr, output, 1 bit: response is a write ack.
REQ-010 SHALL have port quiesce, input, 1 bit: request to stop issuing and drain.
REQ-011 SHALL have port idle, output, 1 bit: halted with nothing outstanding.
REQ-012 SHALL have port MEM_ADDR, output, 23 bits, and port MEM_BWE, output, 9 bits.
REQ-013 SHALL have port MEM_DIN, output, 72 bits, and ports MEM_EN and MEM_RDB_WR, output, 1 bit each.
REQ-014 SHALL have port MEM_DOUT, input, 72 bits: memory read data.

Function
REQ-015 SHALL issue an accepted request on the MEM_* ports in the same cycle as the handshake: MEM_EN=1; MEM_RDB_WR=req_wr; ADDR, BWE and DIN passed through.
REQ-016 SHALL drive MEM_EN=0, MEM_RDB_WR=0 and MEM_BWE=0 in every cycle without a handshake.
REQ-017 SHALL track outstanding = FIFO occupancy + in-flight reads; req_ready=1 only when state is RUN and outstanding < RSP_DEPTH, so the FIFO never overflows.
REQ-018 SHALL carry a RD_LAT-deep valid shift register for reads and push MEM_DOUT into the FIFO exactly RD_LAT cycles after issue.
REQ-019 SHALL return responses in issue order; back-to-back reads at one per cycle SHALL sustain full throughput while rsp_ready=1.
REQ-020 SHALL present rsp_valid from the FIFO head; a pop occurs on rsp_valid && rsp_ready.
REQ-021 SHALL allow a FIFO push and pop in the same cycle; occupancy is then unchanged.
REQ-022 SHALL allow outstanding to reach RSP_DEPTH; req_ready SHALL rise the cycle after a pop frees space.
REQ-023 SHALL wrap FIFO pointers modulo RSP_DEPTH using log2(RSP_DEPTH)+1-bit pointers, with full/empty decided by the MSB.
REQ-024 SHALL implement states RUN, DRAIN and HALT:
- RUN -> DRAIN when quiesce=1.
- DRAIN -> HALT when outstanding=0.
- DRAIN/HALT -> RUN when quiesce=0.
- req_ready=0 in DRAIN and HALT.
REQ-025 SHALL assert idle=1 only in HALT.
REQ-026 SHALL, when quiesce rises in the same cycle as a handshake, complete that request; it counts as outstanding.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set:
- state to RUN;
- FIFO pointers and outstanding to 0;
- shift register to 0;
- rsp_valid=0, req_ready=0, idle=0, MEM_EN=0.
REQ-028 SHALL drop reads in flight when reset occurs mid-operation; no response is produced for them.
REQ-029 SHALL assert req_ready from the first cycle after reset release.

Configuration
REQ-030 SHALL, with URAM_PORT_WR_ACK_EN defined:
- push a response with rsp_wr=1 and rsp_data=0 RD_LAT cycles after each write;
- count writes in outstanding.
REQ-031 SHALL, without URAM_PORT_WR_ACK_EN:
- produce no write responses;
- exclude writes from outstanding;
- tie rsp_wr to 0.

Verification
REQ-032 SHALL cover: write addr 0x10 data 0xA5, then read 0x10 with RD_LAT=2 -> rsp_data=0xA5 with rsp_valid exactly 2 cycles after the read handshake.
REQ-033 SHALL cover: 8 back-to-back reads with rsp_ready=0, RSP_DEPTH=8 -> req_ready=0 after the 8th; 9th request stalls; no data lost.
REQ-034 SHALL cover: continuous reads with rsp_ready=1 -> one response per cycle, in order, with occupancy steady.
REQ-035 SHALL cover: quiesce=1 with 3 reads outstanding -> state DRAIN, req_ready=0; idle=1 the cycle after the 3rd response pops.
REQ-036 SHALL cover: rst_n=0 with 2 reads in flight -> no responses after release and req_ready=1 in the next cycle.
REQ-037 SHALL cover: with URAM_PORT_WR_ACK_EN defined, 4 writes -> 4 responses with rsp_wr=1; with it undefined -> 0 responses.

Source files
------------

// File: rtl/uram_port_master.sv
// uram_port_master: issues requests onto a URAM-style port and returns read data in issue order.
// Define URAM_PORT_WR_ACK_EN to also return a response (rsp_wr=1, rsp_data=0) for every write.
module uram_port_master #(
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [22:0] req_addr,
  input  logic [8:0]  req_bwe,
  input  logic [71:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [71:0] rsp_data,
  output logic        rsp_wr,
  input  logic        quiesce,
  output logic        idle,
  output logic [22:0] MEM_ADDR,
  output logic [8:0]  MEM_BWE,
  output logic [71:0] MEM_DIN,
  output logic        MEM_EN,
  output logic        MEM_RDB_WR,
  input  logic [71:0] MEM_DOUT
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              hs;
  logic              track;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [PW-1:0]     outstanding;
  logic [PW-1:0]     outstanding_nxt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [RD_LAT-1:0] sr_vld;
  logic [71:0]       push_data;
  logic [71:0]       fifo_data [RSP_DEPTH];

  assign hs = req_valid & req_ready;

  assign MEM_EN     = hs;
  assign MEM_RDB_WR = hs & req_wr;
  assign MEM_BWE    = hs ? req_bwe : '0;
  assign MEM_ADDR   = req_addr;
  assign MEM_DIN    = req_data;

`ifdef URAM_PORT_WR_ACK_EN
  logic [RD_LAT-1:0] sr_wr;
  logic              push_wr;
  logic              fifo_wr [RSP_DEPTH];

  assign track     = hs;
  assign push_wr   = sr_wr[RD_LAT-1];
  assign push_data = push_wr ? '0 : MEM_DOUT;
  assign rsp_wr    = fifo_empty ? push_wr : fifo_wr[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_wr <= '0;
    end else begin
      sr_wr[0] <= hs & req_wr;
      for (int i = 1; i < RD_LAT; i++) sr_wr[i] <= sr_wr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_wr[wr_ptr[AW-1:0]] <= push_wr;
  end
`else
  assign track     = hs & ~req_wr;
  assign push_data = MEM_DOUT;
  assign rsp_wr    = 1'b0;
`endif

  // The FIFO falls through when empty so a response is presented in the cycle its data arrives.
  assign push       = sr_vld[RD_LAT-1];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rsp_valid  = ~fifo_empty | push;
  assign rsp_data   = fifo_empty ? push_data : fifo_data[rd_ptr[AW-1:0]];
  assign pop        = rsp_valid & rsp_ready;

  always_comb begin
    outstanding_nxt = outstanding;
    if (track && !pop) begin
      outstanding_nxt = outstanding + PW'(1);
    end else if (!track && pop) begin
      outstanding_nxt = outstanding - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_vld      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      sr_vld[0] <= track;
      for (int i = 1; i < RD_LAT; i++) sr_vld[i] <= sr_vld[i-1];
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      outstanding <= outstanding_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !pop) assert (!fifo_full);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Leaving DRAIN looks at the post-edge count so idle follows the last pop by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (quiesce) state_nxt = DRAIN;
      DRAIN: begin
        if (!quiesce)                     state_nxt = RUN;
        else if (outstanding_nxt == '0)   state_nxt = HALT;
      end
      HALT:    if (!quiesce) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    req_ready = rst_n && (state == RUN) && (outstanding < PW'(RSP_DEPTH));
    idle      = (state == HALT);
  end

endmodule

// File: tb/tb_uram_port_master.sv
// tb_uram_port_master: randomized and directed checks of uram_port_master against a queue-based model.
// A behavioural memory drives MEM_DOUT; expected responses come from a separate reference memory.
module tb_uram_port_master;

  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 8;
  localparam int M_RUN     = 0;
  localparam int M_DRAIN   = 1;
  localparam int M_HALT    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [22:0] req_addr;
  logic [8:0]  req_bwe;
  logic [71:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [71:0] rsp_data;
  logic        rsp_wr;
  logic        quiesce;
  logic        idle;
  logic [22:0] MEM_ADDR;
  logic [8:0]  MEM_BWE;
  logic [71:0] MEM_DIN;
  logic        MEM_EN;
  logic        MEM_RDB_WR;
  logic [71:0] MEM_DOUT;

  always #5 clk = ~clk;

  uram_port_master #(.RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_bwe(req_bwe), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_wr(rsp_wr),
    .quiesce(quiesce), .idle(idle),
    .MEM_ADDR(MEM_ADDR), .MEM_BWE(MEM_BWE), .MEM_DIN(MEM_DIN),
    .MEM_EN(MEM_EN), .MEM_RDB_WR(MEM_RDB_WR), .MEM_DOUT(MEM_DOUT)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int dut_pops = 0;
  int dut_wr_pops = 0;
  bit chk_en = 1'b0;

  function automatic logic [71:0] init_word(input logic [22:0] a);
    return {a[8:0], a[8:0] ^ 9'h0A5, a, ~a, 8'h3C};
  endfunction

  function automatic logic [71:0] merge(input logic [71:0] old, input logic [71:0] d, input logic [8:0] b);
    logic [71:0] r;
    r = old;
    for (int i = 0; i < 9; i++) if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Memory environment: serves the DUT's MEM_* port with a RD_LAT-cycle read pipeline.
  logic [71:0] env_mem [logic [22:0]];
  logic [71:0] pipe [RD_LAT];
  assign MEM_DOUT = pipe[RD_LAT-1];

  always @(posedge clk) begin
    logic [71:0] rd;
    logic [71:0] old;
    rd = 72'({$urandom, $urandom, $urandom});
    if (MEM_EN === 1'b1) begin
      old = env_mem.exists(MEM_ADDR) ? env_mem[MEM_ADDR] : init_word(MEM_ADDR);
      if (MEM_RDB_WR === 1'b1) env_mem[MEM_ADDR] = merge(old, MEM_DIN, MEM_BWE);
      else                     rd = old;
    end
    pipe[0] <= rd;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model: responses are queued in issue order and become visible RD_LAT cycles after issue.
  typedef struct {
    int          due;
    logic [71:0] data;
    logic        wr;
  } ent_t;

  ent_t        inflight [$];
  ent_t        rspq [$];
  logic [71:0] ref_mem [logic [22:0]];
  int          edge_cnt = 0;
  int          m_state = M_RUN;

  function automatic int m_out();
    return rspq.size() + inflight.size();
  endfunction

  function automatic logic exp_ready();
    return (rst_n === 1'b1) && (m_state == M_RUN) && (m_out() < RSP_DEPTH);
  endfunction

  always @(posedge clk) begin
    logic        hs;
    logic [71:0] old;
    if (rst_n !== 1'b1) begin
      inflight.delete();
      rspq.delete();
      m_state = M_RUN;
    end else begin
      hs = req_valid && exp_ready();
      if (rspq.size() > 0 && rsp_ready) void'(rspq.pop_front());
      if (hs) begin
        old = ref_mem.exists(req_addr) ? ref_mem[req_addr] : init_word(req_addr);
        if (req_wr) begin
          ref_mem[req_addr] = merge(old, req_data, req_bwe);
`ifdef URAM_PORT_WR_ACK_EN
          inflight.push_back('{edge_cnt + RD_LAT - 1, 72'h0, 1'b1});
`endif
        end else begin
          inflight.push_back('{edge_cnt + RD_LAT - 1, old, 1'b0});
        end
      end
      while (inflight.size() > 0 && inflight[0].due == edge_cnt) rspq.push_back(inflight.pop_front());
      case (m_state)
        M_RUN:   if (quiesce) m_state = M_DRAIN;
        M_DRAIN: if (!quiesce) m_state = M_RUN; else if (m_out() == 0) m_state = M_HALT;
        default: if (!quiesce) m_state = M_RUN;
      endcase
    end
    edge_cnt++;
  end

  task automatic cmp(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic hs_e;
    hs_e = req_valid && exp_ready();
    cmp("req_ready", 72'(req_ready), 72'(exp_ready()));
    cmp("rsp_valid", 72'(rsp_valid), 72'(rspq.size() > 0));
    if (rspq.size() > 0) begin
      cmp("rsp_data", rsp_data, rspq[0].data);
      cmp("rsp_wr", 72'(rsp_wr), 72'(rspq[0].wr));
    end
    cmp("idle", 72'(idle), 72'(m_state == M_HALT));
    cmp("mem_en", 72'(MEM_EN), 72'(hs_e));
    cmp("mem_rdb_wr", 72'(MEM_RDB_WR), 72'(hs_e && req_wr));
    cmp("mem_bwe", 72'(MEM_BWE), hs_e ? 72'(req_bwe) : 72'h0);
    if (hs_e) begin
      cmp("mem_addr", 72'(MEM_ADDR), 72'(req_addr));
      cmp("mem_din", MEM_DIN, req_data);
    end
  endtask

  always @(negedge clk) if (chk_en) checkOutput();

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      dut_pops++;
      if (rsp_wr === 1'b1) dut_wr_pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [22:0] a, input logic [8:0] b,
                               input logic [71:0] d, input logic rr);
    req_valid = v;
    req_wr    = w;
    req_addr  = a;
    req_bwe   = b;
    req_data  = d;
    rsp_ready = rr;
  endtask

  task automatic idleStim(input logic rr, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 23'($urandom), 9'($urandom), 72'h0, rr);
      tick();
    end
  endtask

  logic [22:0] pool [8];

  initial begin
    int p0;
    int w0;
    rst_n = 1'b0;
    quiesce = 1'b0;
    applyStimulus(1'b0, 1'b0, 23'h0, 9'h0, 72'h0, 1'b0);
    for (int i = 0; i < 8; i++) pool[i] = 23'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;

    @(negedge clk);
    cmp("reset_req_ready", 72'(req_ready), 72'h0);
    cmp("reset_rsp_valid", 72'(rsp_valid), 72'h0);
    cmp("reset_idle", 72'(idle), 72'h0);
    cmp("reset_mem_en", 72'(MEM_EN), 72'h0);
    tick();

    // Write then read back with fixed latency.
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 23'h10, 9'h1FF, 72'hA5, 1'b1);
    @(negedge clk);
    cmp("ready_after_release", 72'(req_ready), 72'h1);
    tick();
    applyStimulus(1'b1, 1'b0, 23'h10, 9'h0, 72'h0, 1'b1);
    @(negedge clk);
    cmp("read_issue_en", 72'(MEM_EN), 72'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 23'h0, 9'h0, 72'h0, 1'b1);
    @(negedge clk);
`ifdef URAM_PORT_WR_ACK_EN
    cmp("wr_ack_valid", 72'(rsp_valid), 72'h1);
    cmp("wr_ack_flag", 72'(rsp_wr), 72'h1);
`else
    cmp("read_not_early", 72'(rsp_valid), 72'h0);
`endif
    tick();
    @(negedge clk);
    cmp("read_lat_valid", 72'(rsp_valid), 72'h1);
    cmp("read_lat_data", rsp_data, 72'hA5);
    cmp("read_lat_wr", 72'(rsp_wr), 72'h0);
    tick();
    idleStim(1'b1, 4);

    // Fill the response FIFO with rsp_ready low, then stall a ninth request.
    p0 = dut_pops;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 23'h100 + 23'(i), 9'h0, 72'h0, 1'b0);
      @(negedge clk);
      cmp("fill_issue", 72'(MEM_EN), 72'h1);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 23'h108, 9'h0, 72'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("full_ready_low", 72'(req_ready), 72'h0);
      cmp("full_stall", 72'(MEM_EN), 72'h0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cmp("full_ready_before_pop", 72'(req_ready), 72'h0);
    tick();
    @(negedge clk);
    cmp("ready_after_pop", 72'(req_ready), 72'h1);
    cmp("ninth_issue", 72'(MEM_EN), 72'h1);
    tick();
    idleStim(1'b1, 12);
    cmp("fill_no_loss", 72'(dut_pops - p0), 72'd9);

    // Continuous reads with rsp_ready high.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 1'b0, 23'h200 + 23'(i), 9'h0, 72'h0, 1'b1);
      @(negedge clk);
      cmp("stream_ready", 72'(req_ready), 72'h1);
      if (i >= RD_LAT) cmp("stream_valid", 72'(rsp_valid), 72'h1);
      tick();
    end
    idleStim(1'b1, 6);

    // Quiesce with three reads outstanding.
    applyStimulus(1'b1, 1'b0, 23'h300, 9'h0, 72'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 23'h301, 9'h0, 72'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 23'h302, 9'h0, 72'h0, 1'b0);
    quiesce = 1'b1;
    @(negedge clk);
    cmp("quiesce_same_cycle_issue", 72'(MEM_EN), 72'h1);
    tick();
    applyStimulus(1'b1, 1'b0, 23'h303, 9'h0, 72'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("drain_ready_low", 72'(req_ready), 72'h0);
      cmp("drain_not_idle", 72'(idle), 72'h0);
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("drain_rsp_valid", 72'(rsp_valid), 72'h1);
      cmp("drain_idle_low", 72'(idle), 72'h0);
      tick();
    end
    @(negedge clk);
    cmp("halt_idle", 72'(idle), 72'h1);
    cmp("halt_ready_low", 72'(req_ready), 72'h0);
    quiesce = 1'b0;
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    cmp("resume_ready", 72'(req_ready), 72'h1);
    cmp("resume_idle_low", 72'(idle), 72'h0);
    tick();

    // Reset with two reads in flight.
    applyStimulus(1'b1, 1'b0, 23'h400, 9'h0, 72'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 23'h401, 9'h0, 72'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 23'h0, 9'h0, 72'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmp("post_reset_ready", 72'(req_ready), 72'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp("post_reset_no_rsp", 72'(rsp_valid), 72'h0);
      tick();
    end

    // Four writes: acknowledged only when write acks are built in.
    p0 = dut_pops;
    w0 = dut_wr_pops;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 23'h500 + 23'(i), 9'($urandom), 72'({$urandom, $urandom, $urandom}), 1'b1);
      tick();
    end
    idleStim(1'b1, 8);
`ifdef URAM_PORT_WR_ACK_EN
    cmp("write_ack_count", 72'(dut_wr_pops - w0), 72'd4);
    cmp("write_rsp_count", 72'(dut_pops - p0), 72'd4);
`else
    cmp("write_ack_count", 72'(dut_wr_pops - w0), 72'd0);
    cmp("write_rsp_count", 72'(dut_pops - p0), 72'd0);
`endif

    // Randomized traffic with quiesce and occasional reset.
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4), pool[$urandom_range(0, 7)],
                    9'($urandom), 72'({$urandom, $urandom, $urandom}), ($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 39) == 0) quiesce = ~quiesce;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    quiesce = 1'b0;
    idleStim(1'b1, 20);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout expected completion at t=%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
